fwd_lookup_engine: RTL and testbench

Forwarding lookup stage that sits directly upstream of the forwarding lookup table. It accepts destination-lookup requests from the ingress parser and buffers them in a small FIFO. For each request it drives the table's forwarding read port, checks the returned entry for valid and tag match, and emits an egress port mask with valid/ready backpressure. It also keeps saturating hit/miss statistics for the host.

---
 rtl/fwd_lookup_engine.sv | 150 +++++++++++++++
 tb/tb_fwd_lookup_engine.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_lookup_engine.sv
// Forwarding lookup stage: queues destination requests, reads the forwarding table,
// resolves the egress port mask with valid/ready output and saturating hit/miss stats.
`timescale 1ns/1ps
`ifndef PORT_NUM
`define PORT_NUM 16
`endif

module fwd_lookup_engine #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SRC_W      = 4,
  parameter int unsigned ID_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [SRC_W-1:0]      req_src,
  input  logic [18:0]           req_key,
  input  logic [ID_W-1:0]       req_id,
  output logic                  fwd_rden,
  output logic [7:0]            fwd_addr,
  input  logic [12+`PORT_NUM-1:0] fwd_rdata,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [ID_W-1:0]       res_id,
  output logic [`PORT_NUM-1:0]  res_mask,
  output logic                  res_hit,
  output logic                  res_drop,
  output logic [15:0]           hit_cnt,
  output logic [15:0]           miss_cnt,
  input  logic                  cnt_clr
);

  localparam int unsigned PN    = `PORT_NUM;
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned REQ_W = SRC_W + 19 + ID_W;
  localparam logic [SRC_W:0] PN_L = (SRC_W+1)'(PN);

  typedef enum logic [1:0] {IDLE, LOOK, RESP} state_t;
  state_t state;

  logic [REQ_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             full, empty, push;
  logic [REQ_W-1:0] head;

  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty     = (wr_ptr == rd_ptr);
  assign req_ready = !full;
  assign push      = req_valid && !full;
  assign head      = fifo_mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= {req_src, req_key, req_id};
  end

  // Pop is tied to the IDLE->LOOK transition, so rd_ptr follows the FSM decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (state == IDLE && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  logic [SRC_W-1:0] w_src;
  logic [10:0]      w_tag;
  logic [ID_W-1:0]  w_id;

  logic          ent_valid, hit, in_range, lk_hit, lk_drop;
  logic [10:0]   ent_tag;
  logic [PN-1:0] ent_mask, src_bit, lk_mask;

  assign ent_valid = fwd_rdata[11+PN];
  assign ent_tag   = fwd_rdata[10+PN:PN];
  assign ent_mask  = fwd_rdata[PN-1:0];
  assign hit       = ent_valid && (ent_tag == w_tag);
  assign in_range  = {1'b0, w_src} < PN_L;
  assign src_bit   = {{(PN-1){1'b0}}, 1'b1} << w_src;
  assign lk_drop   = (lk_mask == '0);

  always_comb begin
    lk_hit  = 1'b0;
    lk_mask = '0;
    if (in_range) begin
      lk_hit  = hit;
      lk_mask = (hit ? ent_mask : '1) & ~src_bit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      fwd_rden  <= 1'b0;
      fwd_addr  <= '0;
      w_src     <= '0;
      w_tag     <= '0;
      w_id      <= '0;
      res_valid <= 1'b0;
      res_id    <= '0;
      res_mask  <= '0;
      res_hit   <= 1'b0;
      res_drop  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (!empty) begin
          w_src    <= head[REQ_W-1 -: SRC_W];
          w_tag    <= head[ID_W+8 +: 11];
          fwd_addr <= head[ID_W +: 8];
          w_id     <= head[ID_W-1:0];
          fwd_rden <= 1'b1;
          state    <= LOOK;
        end
        LOOK: begin
          fwd_rden  <= 1'b0;
          res_valid <= 1'b1;
          res_id    <= w_id;
          res_mask  <= lk_mask;
          res_hit   <= lk_hit;
          res_drop  <= lk_drop;
          state     <= RESP;
        end
        RESP: if (res_ready) begin
          res_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (cnt_clr) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == LOOK && in_range) begin
      if (hit) begin
        if (hit_cnt != '1) hit_cnt <= hit_cnt + 16'd1;
      end else begin
        if (miss_cnt != '1) miss_cnt <= miss_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fwd_lookup_engine.sv
// Self-checking bench for fwd_lookup_engine: vector table plus scoreboard,
// with directed sequences for latency, backpressure, saturation and reset.
`timescale 1ns/1ps
`ifndef PORT_NUM
`define PORT_NUM 16
`endif

module tb_fwd_lookup_engine;

  localparam int unsigned PN    = `PORT_NUM;
  localparam int unsigned ENT_W = 12 + PN;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready;
  logic [4:0]    req_src;
  logic [18:0]   req_key;
  logic [7:0]    req_id;
  logic          fwd_rden;
  logic [7:0]    fwd_addr;
  logic [ENT_W-1:0] fwd_rdata;
  logic          res_valid, res_ready;
  logic [7:0]    res_id;
  logic [PN-1:0] res_mask;
  logic          res_hit, res_drop;
  logic [15:0]   hit_cnt, miss_cnt;
  logic          cnt_clr;

  logic [ENT_W-1:0] tbl [256];
  assign fwd_rdata = tbl[fwd_addr];

  fwd_lookup_engine #(.FIFO_DEPTH(4), .SRC_W(5), .ID_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_src(req_src),
    .req_key(req_key), .req_id(req_id),
    .fwd_rden(fwd_rden), .fwd_addr(fwd_addr), .fwd_rdata(fwd_rdata),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_mask(res_mask), .res_hit(res_hit), .res_drop(res_drop),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  src;
    logic [10:0] tag;
    logic [7:0]  idx;
    logic [7:0]  id;
    logic [15:0] mask;
    logic        hit;
    logic        drop;
  } vec_t;

  typedef struct {
    logic [7:0]  id;
    logic [15:0] mask;
    logic        hit;
    logic        drop;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[8];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: results are consumed on the cycle the handshake completes.
  logic        stalled = 1'b0;
  logic [25:0] held;
  exp_t        e_mon;
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_valid", {31'd0, res_valid}, 32'd1);
        chk("stall_hold", {6'd0, res_id, res_mask, res_hit, res_drop}, {6'd0, held});
      end
      if (res_valid && res_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_result: got id 0x%0h expected no result", res_id);
        end else begin
          e_mon = sb.pop_front();
          chk("res_id",   {24'd0, res_id},   {24'd0, e_mon.id});
          chk("res_mask", {16'd0, res_mask}, {16'd0, e_mon.mask});
          chk("res_hit",  {31'd0, res_hit},  {31'd0, e_mon.hit});
          chk("res_drop", {31'd0, res_drop}, {31'd0, e_mon.drop});
        end
        stalled = 1'b0;
      end else if (res_valid) begin
        stalled = 1'b1;
        held    = {res_id, res_mask, res_hit, res_drop};
      end else begin
        stalled = 1'b0;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input vec_t v);
    int unsigned n;
    exp_t e;
    req_src   = v.src;
    req_key   = {v.tag, v.idx};
    req_id    = v.id;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: got req_ready 0 expected 1 (id 0x%0h)", v.id);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    e.id = v.id; e.mask = v.mask; e.hit = v.hit; e.drop = v.drop;
    sb.push_back(e);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int unsigned n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk); #1;
    chk("drain", sb.size(), 32'd0);
  endtask

  vec_t hv;
  logic seen;

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) tbl[i] = '0;
    tbl[8'h12] = {1'b1, 11'h5A5, 16'h00F0};
    tbl[8'h34] = {1'b0, 11'h5A5, 16'h0F00};
    tbl[8'h56] = {1'b1, 11'h123, 16'h0020};
    tbl[8'h78] = {1'b1, 11'h7FF, 16'hFFFF};

    vecs[0] = '{5'd5,  11'h5A5, 8'h12, 8'h33, 16'h00D0, 1'b1, 1'b0};
    vecs[1] = '{5'd0,  11'h5A4, 8'h12, 8'h34, 16'hFFFE, 1'b0, 1'b0};
    vecs[2] = '{5'd3,  11'h5A5, 8'h34, 8'h35, 16'hFFF7, 1'b0, 1'b0};
    vecs[3] = '{5'd5,  11'h123, 8'h56, 8'h36, 16'h0000, 1'b1, 1'b1};
    vecs[4] = '{5'd16, 11'h5A5, 8'h12, 8'h37, 16'h0000, 1'b0, 1'b1};
    vecs[5] = '{5'd31, 11'h123, 8'h56, 8'h38, 16'h0000, 1'b0, 1'b1};
    vecs[6] = '{5'd15, 11'h7FF, 8'h78, 8'h39, 16'h7FFF, 1'b1, 1'b0};
    vecs[7] = '{5'd4,  11'h123, 8'h56, 8'h3A, 16'h0020, 1'b1, 1'b0};

    rst_n = 1'b0; req_valid = 1'b0; req_src = '0; req_key = '0; req_id = '0;
    res_ready = 1'b0; cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outputs", {7'd0, res_valid, res_id, res_mask}, 32'd0);
    chk("rst_flags", {29'd0, res_hit, res_drop, fwd_rden}, 32'd0);
    chk("rst_addr", {24'd0, fwd_addr}, 32'd0);
    chk("rst_cnts", {hit_cnt, miss_cnt}, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Latency: accept at E0, LOOK during E1..E2, res_valid at E2.
    res_ready = 1'b1;
    send(vecs[0]);
    chk("lat_e0_rden", {31'd0, fwd_rden}, 32'd0);
    @(posedge clk); #1;
    chk("lat_e1_rden", {31'd0, fwd_rden}, 32'd1);
    chk("lat_e1_addr", {24'd0, fwd_addr}, 32'h12);
    chk("lat_e1_valid", {31'd0, res_valid}, 32'd0);
    @(posedge clk); #1;
    chk("lat_e2_valid", {31'd0, res_valid}, 32'd1);
    chk("lat_e2_rden", {31'd0, fwd_rden}, 32'd0);
    wait_drain();
    chk("hit_cnt_1", {16'd0, hit_cnt}, 32'd1);
    chk("miss_cnt_0", {16'd0, miss_cnt}, 32'd0);

    for (int i = 0; i < 8; i++) send(vecs[i]);
    wait_drain();
    chk("hit_cnt_vec", {16'd0, hit_cnt}, 32'd5);
    chk("miss_cnt_vec", {16'd0, miss_cnt}, 32'd2);

    // Backpressure: 1 in RESP plus 4 queued fills the engine.
    res_ready = 1'b0;
    hv = vecs[0];
    for (int i = 0; i < 5; i++) begin
      hv.id = 8'h40 + 8'(i);
      send(hv);
    end
    chk("full_req_ready", {31'd0, req_ready}, 32'd0);
    chk("full_res_valid", {31'd0, res_valid}, 32'd1);
    hv.id = 8'h45;
    fork
      send(hv);
      begin
        repeat (4) @(posedge clk);
        #1;
        chk("full_still", {31'd0, req_ready}, 32'd0);
        res_ready = 1'b1;
      end
    join
    wait_drain();
    chk("hit_cnt_stall", {16'd0, hit_cnt}, 32'd11);

    // Saturation at 0xFFFF.
    force dut.hit_cnt = 16'hFFFF;
    @(posedge clk); #1;
    release dut.hit_cnt;
    chk("sat_preload", {16'd0, hit_cnt}, 32'hFFFF);
    hv.id = 8'h4F;
    send(hv);
    wait_drain();
    chk("sat_hold", {16'd0, hit_cnt}, 32'hFFFF);
    chk("sat_miss", {16'd0, miss_cnt}, 32'd2);

    // Clear wins over an increment in the same LOOK cycle.
    hv.id = 8'h50;
    send(hv);
    @(posedge clk); #1;
    chk("clr_in_look", {31'd0, fwd_rden}, 32'd1);
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    chk("clr_hit", {16'd0, hit_cnt}, 32'd0);
    chk("clr_miss", {16'd0, miss_cnt}, 32'd0);
    wait_drain();
    send(vecs[1]);
    wait_drain();
    chk("post_clr_miss", {16'd0, miss_cnt}, 32'd1);
    chk("post_clr_hit", {16'd0, hit_cnt}, 32'd0);

    // Reset during LOOK with 3 requests still queued.
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      hv.id = 8'h60 + 8'(i);
      send(hv);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    @(posedge clk); #1;
    chk("rmid_in_look", {31'd0, fwd_rden}, 32'd1);
    chk("rmid_hit_pre", {16'd0, hit_cnt}, 32'd1);
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("rmid_outputs", {7'd0, res_valid, res_id, res_mask}, 32'd0);
    chk("rmid_flags", {29'd0, res_hit, res_drop, fwd_rden}, 32'd0);
    chk("rmid_addr", {24'd0, fwd_addr}, 32'd0);
    chk("rmid_cnts", {hit_cnt, miss_cnt}, 32'd0);
    res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rmid_req_ready", {31'd0, req_ready}, 32'd1);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (res_valid || fwd_rden) seen = 1'b1;
    end
    chk("rmid_no_stale", {31'd0, seen}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
